period_scheduler: RTL and testbench
===================================

# period_scheduler

Sequences the school-day period schedule against the wall-clock time word produced by the timer block. Holds a programmable table of class periods (start/end times). Compares the table against the live `{hour, minute}` time and emits the current period index, start/end pulses and a break flag to the seating logic. Re-arms at the timer's day-end reset pulse.

## Interface
- `NUM_PERIODS`, default 8: table depth; legal range 2..16.
- `IW`, default `$clog2(NUM_PERIODS)`: index width.
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: table write strobe.
- `cfg_idx` in IW: table entry to write.
- `cfg_start` in 11: period start time, `{hour[4:0], min[5:0]}`.
- `cfg_end` in 11: period end time, same format.
- `cfg_valid` in 1: valid bit written with the entry. 0 marks end of schedule.
- `run` in 1: level; 1 = schedule armed, 0 = idle and configurable.
- `time_in` in 11: current time `{hour, min}` from the timer.
- `day_rst` in 1: day-end pulse from the timer; restarts the schedule.
- `period_idx` out IW: entry currently waited on or active.
- `in_period` out 1: a period is in progress.
- `period_start` out 1: one-cycle pulse when a period begins.
- `period_end` out 1: one-cycle pulse when a period ends or is truncated.
- `break_active` out 1: between two periods (waiting, idx > 0).
- `day_done` out 1: schedule exhausted for today.
- `cfg_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- Time comparison: 11-bit unsigned compare of the packed word. This is monotonic within a day because minutes occupy the low 6 bits.
- Table: NUM_PERIODS × {start[10:0], end[10:0], valid}. Reset clears all valid bits; start/end are don't-care.
- Writes are accepted only in IDLE.
  - A write in any other state is dropped and pulses `cfg_err`.
  - A write with `cfg_valid=1` and `cfg_end <= cfg_start` is dropped and pulses `cfg_err`.
  - A write with `cfg_valid=0` always succeeds in IDLE.
  - `cfg_idx >= NUM_PERIODS` is dropped and pulses `cfg_err`.
- Entries are processed in ascending index order. The table is required to be time-ascending; the block does not check this.
- FSM states:
  - **IDLE**: all status outputs 0. When `run=1`: idx←0, go to WAIT_START.
  - **WAIT_START**: checks, in priority order:
    - entry[idx] invalid → DAY_DONE.
    - `time_in >= end[idx]` → skip: idx+1 (or DAY_DONE if idx = NUM_PERIODS-1). No pulses.
    - `time_in >= start[idx]` → IN_PERIOD, pulse `period_start`.
  - **IN_PERIOD**: when `time_in >= end[idx]`:
    - pulse `period_end`.
    - if idx < NUM_PERIODS-1 and entry[idx+1] is valid → idx+1, go to WAIT_START.
    - else → DAY_DONE.
  - **DAY_DONE**: `day_done=1`; `period_idx` holds the last index. Waits for `day_rst` or `run=0`.
- Skipping is one entry per cycle. There is no multi-entry jump.
- `day_rst=1` in any non-IDLE state: idx←0, go to WAIT_START next cycle, clear `day_done`. If the block was in IN_PERIOD, pulse `period_end` (truncation).
- `run=0` in any state: go to IDLE next cycle with no pulses. It silently aborts any active period.
- Priority, highest first: `rst`, then `run=0`, then `day_rst`, then normal transitions.
- `day_rst` in IDLE is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- Transition latency: outputs reflect the `time_in`/`run`/`day_rst` value sampled on edge N at edge N+1.
- `period_start` and `period_end` are exactly 1 cycle wide. They are never asserted in the same cycle.
- A period that would start and end at the same sampled time cannot occur, because writes enforce end > start.
- `in_period` rises in the same cycle as `period_start` and falls in the same cycle as `period_end`.
- `break_active = (state==WAIT_START) && idx != 0`.
- `cfg_err` is asserted 1 cycle after the offending `cfg_we` edge.
- A successful write is visible to the FSM from the next cycle.
- `run` rising plus `day_rst` in the same cycle: go to WAIT_START, idx 0.

## Test plan
- Load entries 0..2 = (08:00–08:50), (09:00–09:50), (10:00–10:50), entry 3 invalid. Assert `run` and step `time_in` from 07:59 to 11:00 → `period_start` at 08:00, 09:00 and 10:00; `period_end` at 08:50, 09:50 and 10:50; `break_active` true during 08:50–09:00; `day_done=1` after 10:50.
- Write with cfg_start=09:00, cfg_end=09:00 in IDLE → `cfg_err` pulse, entry unchanged. Any write while `run=1` → `cfg_err`, table unchanged.
- Same table, `run` asserted with `time_in`=09:55 → entries 0 and 1 are skipped in 2 cycles with no pulses; `period_start` fires at 10:00 with `period_idx`=2.
- At 09:20 (idx 1, in period), pulse `day_rst` → `period_end` pulse, `period_idx`=0, WAIT_START; a later `time_in`=08:00 restarts period 0.
- All entries invalid, `run`=1 → `day_done`=1 two cycles later with no pulses. Drop `run` mid-period → IDLE, all outputs 0, no `period_end`.
- `rst` asserted mid-period → all outputs 0 next cycle; the table is invalidated (re-run gives immediate `day_done`).

Source files
------------

// File: rtl/period_scheduler_if.sv
// Configuration, time and status signals between the timer/seating logic and period_scheduler.
// The master drives table writes and time; the slave (the scheduler) returns period status.
interface period_scheduler_if #(
    parameter int NUM_PERIODS = 8,
    parameter int IW          = $clog2(NUM_PERIODS)
);
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [10:0]   cfg_start;
    logic [10:0]   cfg_end;
    logic          cfg_valid;
    logic          run;
    logic [10:0]   time_in;
    logic          day_rst;

    logic [IW-1:0] period_idx;
    logic          in_period;
    logic          period_start;
    logic          period_end;
    logic          break_active;
    logic          day_done;
    logic          cfg_err;

    modport master (
        output cfg_we, cfg_idx, cfg_start, cfg_end, cfg_valid, run, time_in, day_rst,
        input  period_idx, in_period, period_start, period_end, break_active, day_done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_start, cfg_end, cfg_valid, run, time_in, day_rst,
        output period_idx, in_period, period_start, period_end, break_active, day_done, cfg_err
    );
endinterface

// File: rtl/period_scheduler.sv
// Walks a programmable table of {start,end} class periods against the live {hour,min} word
// and reports the current period, start/end pulses, break and day-done status.
module period_scheduler #(
    parameter int NUM_PERIODS = 8,
    parameter int IW          = $clog2(NUM_PERIODS)
) (
    input  logic              clk,
    input  logic              rst,
    period_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_IN_PERIOD,
        S_DAY_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PERIODS - 1);

    logic [10:0]            r_start [NUM_PERIODS];
    logic [10:0]            r_end   [NUM_PERIODS];
    logic [NUM_PERIODS-1:0] r_valid;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_next_idx;
    logic [IW-1:0] w_idx_inc;

    logic          r_in_period;
    logic          r_period_start;
    logic          r_period_end;
    logic          r_break_active;
    logic          r_day_done;
    logic          r_cfg_err;

    logic          w_cur_valid;
    logic          w_nxt_valid;
    logic          w_past_start;
    logic          w_past_end;
    logic          w_start_pulse;
    logic          w_end_pulse;
    logic          w_idx_oob;
    logic          w_wr_bad;
    logic          w_wr_ok;

    assign w_idx_inc    = r_idx + 1'b1;
    assign w_cur_valid  = r_valid[r_idx];
    assign w_nxt_valid  = (r_idx != LAST_IDX) && r_valid[w_idx_inc];
    assign w_past_start = bus.time_in >= r_start[r_idx];
    assign w_past_end   = bus.time_in >= r_end[r_idx];

    // Writes are only legal while idle, in range, and (for valid entries) with a non-empty window.
    assign w_idx_oob = {1'b0, bus.cfg_idx} >= (IW+1)'(NUM_PERIODS);
    assign w_wr_bad  = (r_state != S_IDLE) || w_idx_oob ||
                       (bus.cfg_valid && (bus.cfg_end <= bus.cfg_start));
    assign w_wr_ok   = bus.cfg_we && !w_wr_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_wr_ok) begin
            r_valid[bus.cfg_idx] <= bus.cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_start[bus.cfg_idx] <= bus.cfg_start;
            r_end[bus.cfg_idx]   <= bus.cfg_end;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_start_pulse = 1'b0;
        w_end_pulse   = 1'b0;
        if (!bus.run) begin
            w_next_state = S_IDLE;
            w_next_idx   = '0;
        end else if (r_state == S_IDLE) begin
            w_next_state = S_WAIT_START;
            w_next_idx   = '0;
        end else if (bus.day_rst) begin
            // Day rollover truncates any running period.
            w_next_state = S_WAIT_START;
            w_next_idx   = '0;
            w_end_pulse  = (r_state == S_IN_PERIOD);
        end else begin
            case (r_state)
                S_WAIT_START: begin
                    if (!w_cur_valid) begin
                        w_next_state = S_DAY_DONE;
                    end else if (w_past_end) begin
                        if (r_idx == LAST_IDX) begin
                            w_next_state = S_DAY_DONE;
                        end else begin
                            w_next_idx = w_idx_inc;
                        end
                    end else if (w_past_start) begin
                        w_next_state  = S_IN_PERIOD;
                        w_start_pulse = 1'b1;
                    end
                end
                S_IN_PERIOD: begin
                    if (w_past_end) begin
                        w_end_pulse = 1'b1;
                        if (w_nxt_valid) begin
                            w_next_state = S_WAIT_START;
                            w_next_idx   = w_idx_inc;
                        end else begin
                            w_next_state = S_DAY_DONE;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_in_period    <= 1'b0;
            r_period_start <= 1'b0;
            r_period_end   <= 1'b0;
            r_break_active <= 1'b0;
            r_day_done     <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_idx          <= w_next_idx;
            r_in_period    <= (w_next_state == S_IN_PERIOD);
            r_period_start <= w_start_pulse;
            r_period_end   <= w_end_pulse;
            r_break_active <= (w_next_state == S_WAIT_START) && (w_next_idx != '0);
            r_day_done     <= (w_next_state == S_DAY_DONE);
            r_cfg_err      <= bus.cfg_we && w_wr_bad;
        end
    end

    assign bus.period_idx   = r_idx;
    assign bus.in_period    = r_in_period;
    assign bus.period_start = r_period_start;
    assign bus.period_end   = r_period_end;
    assign bus.break_active = r_break_active;
    assign bus.day_done     = r_day_done;
    assign bus.cfg_err      = r_cfg_err;
endmodule

// File: tb/tb_period_scheduler.sv
// Scoreboard bench for period_scheduler: a time-table reference model predicts every cycle's
// outputs into a queue, and an independent monitor compares them just after each clock edge.
module tb_period_scheduler;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef logic [IW+5:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    period_scheduler_if #(.NUM_PERIODS(N), .IW(IW)) bus ();

    period_scheduler #(.NUM_PERIODS(N), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the table as plain minute-words, plus where we are in the school day.
    int   mStart [N];
    int   mEnd   [N];
    bit   mValid [N];
    bit   armed;
    bit   inPer;
    bit   done;
    int   idx;
    obs_t expQ [$];
    int   total = 0;
    int   bad   = 0;
    int   curT;

    function automatic int hm(input int h, input int m);
        return h * 64 + m;
    endfunction

    function automatic int addMin(input int t, input int d);
        int h;
        int m;
        h = t / 64;
        m = (t % 64) + d;
        while (m >= 60) begin
            m = m - 60;
            h = h + 1;
        end
        if (h > 23) begin
            h = 23;
            m = 59;
        end
        return h * 64 + m;
    endfunction

    task automatic applyStimulus(input bit r, input bit runV, input int t, input bit dr,
                                 input bit we, input int wi, input int ws, input int wend,
                                 input bit wv);
        bit ps;
        bit pe;
        bit err;
        bit brk;
        ps  = 1'b0;
        pe  = 1'b0;
        err = 1'b0;
        rst           = r;
        bus.run       = runV;
        bus.time_in   = 11'(t);
        bus.day_rst   = dr;
        bus.cfg_we    = we;
        bus.cfg_idx   = IW'(wi);
        bus.cfg_start = 11'(ws);
        bus.cfg_end   = 11'(wend);
        bus.cfg_valid = wv;
        if (r) begin
            for (int i = 0; i < N; i++) mValid[i] = 1'b0;
            armed = 1'b0;
            inPer = 1'b0;
            done  = 1'b0;
            idx   = 0;
        end else begin
            err = we && (armed || wi >= N || (wv && wend <= ws));
            if (!runV) begin
                armed = 1'b0;
                inPer = 1'b0;
                done  = 1'b0;
                idx   = 0;
            end else if (!armed) begin
                armed = 1'b1;
                inPer = 1'b0;
                done  = 1'b0;
                idx   = 0;
            end else if (dr) begin
                pe    = inPer;
                inPer = 1'b0;
                done  = 1'b0;
                idx   = 0;
            end else if (done) begin
                done = 1'b1;
            end else if (!inPer) begin
                if (!mValid[idx]) begin
                    done = 1'b1;
                end else if (t >= mEnd[idx]) begin
                    if (idx == N - 1) done = 1'b1;
                    else idx = idx + 1;
                end else if (t >= mStart[idx]) begin
                    inPer = 1'b1;
                    ps    = 1'b1;
                end
            end else if (t >= mEnd[idx]) begin
                pe    = 1'b1;
                inPer = 1'b0;
                if (idx < N - 1 && mValid[idx+1]) idx = idx + 1;
                else done = 1'b1;
            end
            if (we && !err) begin
                mValid[wi] = wv;
                mStart[wi] = ws;
                mEnd[wi]   = wend;
            end
        end
        brk = armed && !inPer && !done && (idx != 0);
        expQ.push_back({IW'(idx), inPer, ps, pe, brk, done, err});
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input bit runV, input int t, input bit dr);
        applyStimulus(1'b0, runV, t, dr, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic writeEntry(input bit runV, input int t, input int wi, input int ws,
                              input int wend, input bit wv);
        applyStimulus(1'b0, runV, t, 1'b0, 1'b1, wi, ws, wend, wv);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic loadDefault();
        writeEntry(1'b0, curT, 0, hm(8, 0), hm(8, 50), 1'b1);
        writeEntry(1'b0, curT, 1, hm(9, 0), hm(9, 50), 1'b1);
        writeEntry(1'b0, curT, 2, hm(10, 0), hm(10, 50), 1'b1);
        writeEntry(1'b0, curT, 3, 0, 0, 1'b0);
    endtask

    task automatic checkOutput(input obs_t e);
        obs_t a;
        a = {bus.period_idx, bus.in_period, bus.period_start, bus.period_end,
             bus.break_active, bus.day_done, bus.cfg_err};
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL outputs t=%0t: got idx=%0d inp=%b ps=%b pe=%b brk=%b dd=%b err=%b, want idx=%0d inp=%b ps=%b pe=%b brk=%b dd=%b err=%b",
                     $time, a[IW+5:6], a[5], a[4], a[3], a[2], a[1], a[0],
                     e[IW+5:6], e[5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    // Monitor: independent of stimulus, pops one prediction per edge once outputs settle.
    obs_t monExp;
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput(monExp);
        end
    end

    initial begin
        bit runR;
        bit dr;
        int k;
        int t;
        int s;
        int e;
        curT = hm(7, 0);
        for (int i = 0; i < N; i++) begin
            mStart[i] = 0;
            mEnd[i]   = 0;
            mValid[i] = 1'b0;
        end
        armed = 1'b0;
        inPer = 1'b0;
        done  = 1'b0;
        idx   = 0;

        repeat (3) doReset();
        tick(1'b0, curT, 1'b0);

        // Full-day sweep with rejected writes before and during the run.
        loadDefault();
        writeEntry(1'b0, curT, 4, hm(9, 0), hm(9, 0), 1'b1);
        tick(1'b0, curT, 1'b0);
        curT = hm(7, 59);
        while (curT <= hm(11, 0)) begin
            if (curT == hm(9, 30))
                writeEntry(1'b1, curT, 5, hm(12, 0), hm(12, 30), 1'b1);
            else
                tick(1'b1, curT, 1'b0);
            curT = addMin(curT, 1);
        end
        repeat (2) tick(1'b0, curT, 1'b0);

        // Late arm: entries 0 and 1 skipped one per cycle.
        curT = hm(9, 55);
        tick(1'b0, curT, 1'b0);
        repeat (4) tick(1'b1, curT, 1'b0);
        curT = hm(10, 0);
        repeat (3) tick(1'b1, curT, 1'b0);
        tick(1'b0, curT, 1'b0);

        // Day reset mid-period, then restart at 08:00.
        curT = hm(9, 20);
        repeat (4) tick(1'b1, curT, 1'b0);
        tick(1'b1, curT, 1'b1);
        curT = hm(7, 30);
        repeat (2) tick(1'b1, curT, 1'b0);
        curT = hm(8, 0);
        repeat (3) tick(1'b1, curT, 1'b0);
        tick(1'b0, curT, 1'b0);
        tick(1'b0, curT, 1'b0);

        // Run dropped at the same instant as day_rst: abort wins, no end pulse.
        curT = hm(8, 10);
        repeat (3) tick(1'b1, curT, 1'b0);
        tick(1'b0, curT, 1'b1);
        tick(1'b0, curT, 1'b1);

        // Reset mid-period invalidates the table.
        repeat (3) tick(1'b1, curT, 1'b0);
        doReset();
        repeat (4) tick(1'b1, curT, 1'b0);
        tick(1'b0, curT, 1'b0);

        // Randomised tables and time walks.
        for (int iter = 0; iter < 20; iter++) begin
            if ($urandom_range(0, 3) == 0) doReset();
            tick(1'b0, curT, 1'b0);
            k = $urandom_range(0, N);
            t = hm(7, $urandom_range(0, 59));
            for (int i = 0; i < N; i++) begin
                s = addMin(t, $urandom_range(0, 20));
                e = addMin(s, $urandom_range(1, 40));
                if ($urandom_range(0, 9) == 0) e = s;
                writeEntry(1'b0, curT, i, s, e, (i < k));
                t = e;
            end
            curT = hm(7, $urandom_range(0, 59));
            runR = 1'b1;
            for (int c = 0; c < 50; c++) begin
                dr = ($urandom_range(0, 19) == 0);
                if (dr) curT = hm(7, $urandom_range(0, 59));
                else curT = addMin(curT, $urandom_range(0, 6));
                if ($urandom_range(0, 39) == 0) runR = 1'b0;
                else runR = 1'b1;
                if ($urandom_range(0, 14) == 0)
                    applyStimulus(1'b0, runR, curT, dr, 1'b1, $urandom_range(0, N - 1),
                                  hm(12, 0), hm(12, 30), 1'b1);
                else
                    tick(runR, curT, dr);
            end
            tick(1'b0, curT, 1'b0);
        end

        tick(1'b0, curT, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending predictions, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
